// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Brief   : Two-master arbiter in front of one native-memory slave, one
//           outstanding transaction. Optional watchdog: MEM_ARB_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module mem_arbiter #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int FIXED_PRIO     = 0,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  m0_valid,
   input  logic                  m0_instr,
   input  logic [ADDR_W-1:0]     m0_addr,
   input  logic [DATA_W-1:0]     m0_wdata,
   input  logic [DATA_W/8-1:0]   m0_wstrb,
   output logic                  m0_ready,
   output logic [DATA_W-1:0]     m0_rdata,
   input  logic                  m1_valid,
   input  logic                  m1_instr,
   input  logic [ADDR_W-1:0]     m1_addr,
   input  logic [DATA_W-1:0]     m1_wdata,
   input  logic [DATA_W/8-1:0]   m1_wstrb,
   output logic                  m1_ready,
   output logic [DATA_W-1:0]     m1_rdata,
   output logic                  s_valid,
   output logic                  s_instr,
   output logic [ADDR_W-1:0]     s_addr,
   output logic [DATA_W-1:0]     s_wdata,
   output logic [DATA_W/8-1:0]   s_wstrb,
   input  logic                  s_ready,
   input  logic [DATA_W-1:0]     s_rdata,
   output logic [1:0]            grant,
   output logic                  timeout_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            r_state;
   logic              r_last;   // 1: m1 was the most recent owner
   logic              r_owner;  // 1: m1 owns the current transaction
   logic              w_take_m1;
   logic              w_done;
   logic              w_wd_hit;
   logic [DATA_W-1:0] w_resp_data;

   always_comb begin
      w_take_m1 = m1_valid;
      if (m0_valid && m1_valid)
         w_take_m1 = (FIXED_PRIO == 0) ? !r_last : 1'b0;
   end

`ifdef MEM_ARB_TIMEOUT_EN
   localparam logic [15:0]       WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_BEEF);
   logic [15:0] r_wd_cnt;
   assign w_wd_hit    = (r_wd_cnt == WD_LIMIT);
   // A real completion arriving on the limit cycle takes precedence.
   assign w_resp_data = s_ready ? s_rdata : ERR_DATA;
`else
   assign w_wd_hit    = 1'b0;
   assign w_resp_data = s_rdata;
   assign timeout_err = 1'b0;
`endif

   assign w_done = s_ready || w_wd_hit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_last   <= 1'b1;
         r_owner  <= 1'b0;
         s_valid  <= 1'b0;
         s_instr  <= 1'b0;
         s_addr   <= '0;
         s_wdata  <= '0;
         s_wstrb  <= '0;
         m0_ready <= 1'b0;
         m1_ready <= 1'b0;
         m0_rdata <= '0;
         m1_rdata <= '0;
         grant    <= 2'b00;
`ifdef MEM_ARB_TIMEOUT_EN
         r_wd_cnt    <= '0;
         timeout_err <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (m0_valid || m1_valid) begin
                  r_owner <= w_take_m1;
                  r_last  <= w_take_m1;
                  grant   <= w_take_m1 ? 2'b10 : 2'b01;
                  s_valid <= 1'b1;
                  s_instr <= w_take_m1 ? m1_instr : m0_instr;
                  s_addr  <= w_take_m1 ? m1_addr  : m0_addr;
                  s_wdata <= w_take_m1 ? m1_wdata : m0_wdata;
                  s_wstrb <= w_take_m1 ? m1_wstrb : m0_wstrb;
`ifdef MEM_ARB_TIMEOUT_EN
                  r_wd_cnt <= '0;
`endif
                  r_state <= BUSY;
               end
            end
            BUSY: begin
               if (w_done) begin
                  s_valid <= 1'b0;
                  if (r_owner) m1_ready <= 1'b1;
                  else         m0_ready <= 1'b1;
                  // Writes leave the master's read data untouched.
                  if (s_wstrb == '0) begin
                     if (r_owner) m1_rdata <= w_resp_data;
                     else         m0_rdata <= w_resp_data;
                  end
`ifdef MEM_ARB_TIMEOUT_EN
                  if (!s_ready) timeout_err <= 1'b1;
`endif
                  r_state <= RESP;
               end
`ifdef MEM_ARB_TIMEOUT_EN
               else begin
                  r_wd_cnt <= r_wd_cnt + 16'd1;
               end
`endif
            end
            RESP: begin
               m0_ready <= 1'b0;
               m1_ready <= 1'b0;
               grant    <= 2'b00;
               r_state  <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Brief   : Bench for mem_arbiter; instance 0 round-robin, instance 1 fixed
//           priority, each fronting a behavioural BRAM slave.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst [2];
   logic        mv  [2][2];
   logic        mi  [2][2];
   logic [31:0] ma  [2][2];
   logic [31:0] mw  [2][2];
   logic [3:0]  ms  [2][2];
   logic        mr  [2][2];
   logic [31:0] mrd [2][2];
   logic        sv  [2];
   logic        si  [2];
   logic [31:0] sa  [2];
   logic [31:0] sw  [2];
   logic [3:0]  ss  [2];
   logic        sr  [2];
   logic [31:0] srd [2];
   logic [1:0]  gnt [2];
   logic        terr[2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      mem_arbiter #(
         .ADDR_W(32), .DATA_W(32), .FIXED_PRIO(g), .TIMEOUT_CYCLES(8)
      ) u_dut (
         .clk(clk), .reset(rst[g]),
         .m0_valid(mv[g][0]), .m0_instr(mi[g][0]), .m0_addr(ma[g][0]),
         .m0_wdata(mw[g][0]), .m0_wstrb(ms[g][0]), .m0_ready(mr[g][0]), .m0_rdata(mrd[g][0]),
         .m1_valid(mv[g][1]), .m1_instr(mi[g][1]), .m1_addr(ma[g][1]),
         .m1_wdata(mw[g][1]), .m1_wstrb(ms[g][1]), .m1_ready(mr[g][1]), .m1_rdata(mrd[g][1]),
         .s_valid(sv[g]), .s_instr(si[g]), .s_addr(sa[g]), .s_wdata(sw[g]), .s_wstrb(ss[g]),
         .s_ready(sr[g]), .s_rdata(srd[g]), .grant(gnt[g]), .timeout_err(terr[g])
      );
   end

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // Scoreboard (index d*2+m) and reference memory
   logic [31:0] sb [4][$];
   logic [31:0] last_rd [4];
   logic [31:0] model [2][16];
   logic [31:0] smem  [2][16];
   logic [31:0] mon_exp;
   int          ready_time [4];
   int          ready_cnt  [4];
   logic        prev_r     [4];
   logic        prev_sv    [2];
   int          rise_edge  [2];
   int          sready_edge[2];
   int          slave_en   [2];
   int          lat        [2];
   int          wcnt       [2];

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Behavioural slave: answers after lat[d] waiting cycles
   initial forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         sr[d] = 1'b0;
         if (sv[d] === 1'b1 && slave_en[d] != 0) begin
            if (wcnt[d] >= lat[d]) begin
               sr[d] = 1'b1;
               sready_edge[d] = cyc + 1;
               wcnt[d] = 0;
               if (ss[d] == 4'b0000) begin
                  srd[d] = smem[d][sa[d][5:2]];
               end else begin
                  srd[d] = $urandom;
                  for (int b = 0; b < 4; b++)
                     if (ss[d][b]) smem[d][sa[d][5:2]][8*b +: 8] = sw[d][8*b +: 8];
               end
            end else begin
               wcnt[d]++;
            end
         end else begin
            wcnt[d] = 0;
         end
      end
   end

   // Response monitor: pops the scoreboard on every master ready
   initial forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         for (int m = 0; m < 2; m++) begin
            if (mr[d][m] === 1'b1) begin
               checks++;
               if (sb[d*2+m].size() == 0) begin
                  errors++;
                  $display("FAIL ready_unexpected inst%0d m%0d: ready=1, required 0", d, m);
               end else begin
                  mon_exp = sb[d*2+m].pop_front();
                  if (mrd[d][m] !== mon_exp) begin
                     errors++;
                     $display("FAIL rdata inst%0d m%0d: got %h, required %h", d, m, mrd[d][m], mon_exp);
                  end
               end
               checks++;
               if (gnt[d] !== ((m == 0) ? 2'b01 : 2'b10)) begin
                  errors++;
                  $display("FAIL grant_at_ready inst%0d m%0d: got %b", d, m, gnt[d]);
               end
               checks++;
               if (prev_r[d*2+m]) begin
                  errors++;
                  $display("FAIL ready_pulse inst%0d m%0d: ready high two cycles, required one", d, m);
               end
               ready_time[d*2+m] = cyc;
               ready_cnt[d*2+m]++;
            end
            prev_r[d*2+m] = (mr[d][m] === 1'b1);
         end
         if (sv[d] === 1'b1 && !prev_sv[d]) rise_edge[d] = cyc + 1;
         prev_sv[d] = (sv[d] === 1'b1);
      end
   end

   task automatic do_req(input int d, input int m, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         input int hold, input int drop, input int tmo);
      int k;
      bit got;
      logic [31:0] e;
      k = d * 2 + m;
      if (strb == 4'b0000) begin
         e = tmo ? 32'hDEAD_BEEF : model[d][addr[5:2]];
         last_rd[k] = e;
      end else begin
         for (int b = 0; b < 4; b++)
            if (strb[b]) model[d][addr[5:2]][8*b +: 8] = wdata[8*b +: 8];
         e = last_rd[k];
      end
      sb[k].push_back(e);
      mv[d][m] = 1'b1; mi[d][m] = addr[2]; ma[d][m] = addr;
      mw[d][m] = wdata; ms[d][m] = strb;
      got = 1'b0;
      for (int i = 0; i < 80 && !got; i++) begin
         @(negedge clk);
         if (drop != 0 && gnt[d][m] === 1'b1) mv[d][m] = 1'b0;
         if (mr[d][m] === 1'b1) got = 1'b1;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL req_complete inst%0d m%0d addr %h: ready=0 after 80 cycles, required 1", d, m, addr);
      end
      if (hold == 0) mv[d][m] = 1'b0;
   endtask

   task automatic do_reset(input int d);
      rst[d] = 1'b1;
      repeat (2) @(negedge clk);
      rst[d] = 1'b0;
      last_rd[d*2] = 32'h0;
      last_rd[d*2+1] = 32'h0;
   endtask

   task automatic test_reset();
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; slave_en[d] = 1; lat[d] = 1; wcnt[d] = 0;
         sr[d] = 1'b0; srd[d] = 32'h0; prev_sv[d] = 1'b0;
         for (int m = 0; m < 2; m++) begin
            mv[d][m] = 1'b0; mi[d][m] = 1'b0; ma[d][m] = 32'h0;
            mw[d][m] = 32'h0; ms[d][m] = 4'h0;
            last_rd[d*2+m] = 32'h0; ready_cnt[d*2+m] = 0; prev_r[d*2+m] = 1'b0;
         end
         for (int a = 0; a < 16; a++) begin
            model[d][a] = 32'h1000 * a + 32'h5A;
            smem[d][a]  = 32'h1000 * a + 32'h5A;
         end
      end
      repeat (3) @(negedge clk);
      for (int ph = 0; ph < 2; ph++) begin
         for (int d = 0; d < 2; d++) begin
            checks++;
            if ({sv[d], si[d], sa[d], sw[d], ss[d], gnt[d], terr[d], mr[d][0], mr[d][1],
                 mrd[d][0], mrd[d][1]} !== '0) begin
               errors++;
               $display("FAIL reset_state inst%0d phase%0d: s_valid=%b grant=%b terr=%b rdata0=%h, required all 0",
                        d, ph, sv[d], gnt[d], terr[d], mrd[d][0]);
            end
         end
         rst[0] = 1'b0; rst[1] = 1'b0;
         repeat (2) @(negedge clk);
      end
   endtask

   task automatic test_write_read();
      do_req(0, 0, 32'h0, 32'h0000_1111, 4'b1111, 0, 0, 0);
      do_req(0, 0, 32'h0, 32'h0, 4'b0000, 0, 0, 0);
      checks++;
      if (mrd[0][0] !== 32'h0000_1111) begin
         errors++;
         $display("FAIL write_read: m0_rdata=%h, required 00001111", mrd[0][0]);
      end
      checks++;
      if (ready_cnt[1] != 0) begin
         errors++;
         $display("FAIL m1_quiet: m1 ready pulses=%0d, required 0", ready_cnt[1]);
      end
   endtask

   task automatic test_tie_rr();
      do_reset(0);
      for (int r = 0; r < 2; r++) begin
         fork
            do_req(0, 0, 32'h4, 32'h0, 4'b0000, 0, 0, 0);
            do_req(0, 1, 32'h8, 32'h0, 4'b0000, 0, 0, 0);
         join
         checks++;
         if (!(ready_time[0] < ready_time[1])) begin
            errors++;
            $display("FAIL tie_rr round%0d: m0 done @%0d m1 done @%0d, required m0 first", r, ready_time[0], ready_time[1]);
         end
      end
   endtask

   task automatic test_fixed_prio();
      fork
         begin
            do_req(1, 0, 32'h10, 32'h0, 4'b0000, 1, 0, 0);
            do_req(1, 0, 32'h14, 32'hA5A5_0001, 4'b0011, 1, 0, 0);
            do_req(1, 0, 32'h18, 32'h0, 4'b0000, 0, 0, 0);
         end
         do_req(1, 1, 32'h20, 32'h0, 4'b0000, 0, 0, 0);
      join
      checks++;
      if (!(ready_time[3] > ready_time[2])) begin
         errors++;
         $display("FAIL fixed_prio: m1 done @%0d m0 last done @%0d, required m1 after m0", ready_time[3], ready_time[2]);
      end
   endtask

   task automatic test_pending();
      int tk;
      bit seen;
      lat[0] = 3;
      tk = 0;
      fork
         begin
            do_req(0, 0, 32'h24, 32'h0, 4'b0000, 0, 0, 0);
            tk = sready_edge[0];
         end
         begin
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
               @(negedge clk);
               if (sv[0] === 1'b1) seen = 1'b1;
            end
            do_req(0, 1, 32'h28, 32'h0, 4'b0000, 0, 0, 0);
         end
      join
      checks++;
      if (rise_edge[0] - tk != 3) begin
         errors++;
         $display("FAIL pending_gap: s_valid rose %0d edges after s_ready, required 3", rise_edge[0] - tk);
      end
      lat[0] = 1;
   endtask

   task automatic test_drop_valid();
      do_req(0, 1, 32'h2C, 32'h0, 4'b0000, 0, 1, 0);
      do_req(0, 0, 32'h30, 32'hCAFE_0000, 4'b1100, 0, 1, 0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 12; i++) begin
         lat[0] = $urandom_range(0, 2);
         do_req(0, $urandom_range(0, 1), {26'h0, 4'($urandom_range(0, 15)), 2'b00}, $urandom,
                ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'b0000, 0, 0, 0);
      end
      lat[0] = 1;
   endtask

   task automatic test_reset_busy();
      bit seen;
      int c0;
      slave_en[0] = 0;
      mv[0][0] = 1'b1; ma[0][0] = 32'h34; ms[0][0] = 4'b0000;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (sv[0] === 1'b1) seen = 1'b1;
      end
      @(negedge clk);
      rst[0] = 1'b1;
      #1;
      checks++;
      if (sv[0] !== 1'b0 || gnt[0] !== 2'b00) begin
         errors++;
         $display("FAIL reset_abort: s_valid=%b grant=%b, required 0 and 00", sv[0], gnt[0]);
      end
      mv[0][0] = 1'b0;
      c0 = ready_cnt[0];
      repeat (2) @(negedge clk);
      rst[0] = 1'b0;
      last_rd[0] = 32'h0; last_rd[1] = 32'h0;
      repeat (10) @(negedge clk);
      checks++;
      if (ready_cnt[0] != c0) begin
         errors++;
         $display("FAIL reset_no_ready: %0d ready pulses after abort, required 0", ready_cnt[0] - c0);
      end
      slave_en[0] = 1;
   endtask

   task automatic test_timeout();
`ifdef MEM_ARB_TIMEOUT_EN
      slave_en[0] = 0;
      do_req(0, 0, 32'h38, 32'h0, 4'b0000, 0, 0, 1);
      checks++;
      if (ready_time[0] - rise_edge[0] + 1 != 8) begin
         errors++;
         $display("FAIL timeout_len: ready after %0d busy cycles, required 8", ready_time[0] - rise_edge[0] + 1);
      end
      checks++;
      if (terr[0] !== 1'b1) begin
         errors++;
         $display("FAIL timeout_err: got %b, required 1", terr[0]);
      end
      slave_en[0] = 1;
`else
      checks++;
      if (terr[0] !== 1'b0 || terr[1] !== 1'b0) begin
         errors++;
         $display("FAIL timeout_err_tied: got %b%b, required 00", terr[0], terr[1]);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_tie_rr();
      test_fixed_prio();
      test_pending();
      test_drop_valid();
      test_random();
      test_reset_busy();
      test_timeout();
      repeat (4) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (sb[k].size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain q%0d: %0d responses missing, required 0", k, sb[k].size());
         end
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
